lfsr_burst_gen: RTL

Parametrised Fibonacci LFSR test-pattern generator: the next generation of the team's 3-bit LFSR with selectable two-tap feedback. It has a run-time tap mask, XOR/XNOR mode, seed load, lock-up detection with automatic recovery, and burst delivery over a valid/ready stream. It sits in the test-pattern path and feeds pattern words to downstream checkers and displays.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_next_state.sv | 27 ++
 rtl/lfsr_burst_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and lock-up helpers for the burst LFSR pattern generator.
// Helpers work at MaxWidth bits; callers size-cast the result to their own width.
package lfsr_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [MaxWidth-1:0] lockup_value(input logic xnor_mode);
        return {MaxWidth{xnor_mode}};
    endfunction

    function automatic logic [MaxWidth-1:0] recover_value(input logic                xnor_mode,
                                                          input logic [MaxWidth-1:0] seed);
        return xnor_mode ? ~seed : seed;
    endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational next-state for the Fibonacci LFSR, with lock-up detection and recovery.
// step_i = 0 passes state_i through unshifted so a loaded seed gets the same lock-up check.
module lfsr_next_state import lfsr_pkg::*; #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] taps_i,
    input  logic             xnor_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] next_o,
    output logic             recover_o
);

    logic             fb;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] lock_val;
    logic [WIDTH-1:0] rec_val;

    assign fb        = (^(state_i & taps_i)) ^ xnor_i;
    assign cand      = step_i ? {state_i[WIDTH-2:0], fb} : state_i;
    assign lock_val  = WIDTH'(lockup_value(xnor_i));
    assign rec_val   = WIDTH'(recover_value(xnor_i, MaxWidth'(RESET_SEED)));
    assign recover_o = (cand == lock_val);
    assign next_o    = recover_o ? rec_val : cand;

endmodule

// File: rtl/lfsr_burst_gen.sv
// LFSR test-pattern generator delivering bursts of state words over a valid/ready stream.
// Run-time tap mask and XOR/XNOR mode; lock-up values are replaced by a recovery seed.
module lfsr_burst_gen import lfsr_pkg::*; #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] taps_i,
    input  logic             xnor_mode_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] burst_len_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             lockup_o,
    input  logic             lockup_clr_i
);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic             xnor_q, xnor_d;
    logic             lockup_q, lockup_d;
    logic             lock_set;

    logic             load_sel;
    logic [WIDTH-1:0] ns_src, ns_taps, ns_next;
    logic             ns_xnor, ns_recover;

    // A load in IDLE checks the seed with the incoming taps/mode; otherwise step the live state.
    assign load_sel = (st_q == StIdle) && load_i;
    assign ns_src   = load_sel ? seed_i      : lfsr_q;
    assign ns_taps  = load_sel ? taps_i      : taps_q;
    assign ns_xnor  = load_sel ? xnor_mode_i : xnor_q;

    lfsr_next_state #(
        .WIDTH      (WIDTH),
        .RESET_SEED (RESET_SEED)
    ) u_next (
        .state_i   (ns_src),
        .taps_i    (ns_taps),
        .xnor_i    (ns_xnor),
        .step_i    (~load_sel),
        .next_o    (ns_next),
        .recover_o (ns_recover)
    );

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        taps_d   = taps_q;
        xnor_d   = xnor_q;
        lock_set = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (load_i || start_i) begin
                    taps_d = taps_i;
                    xnor_d = xnor_mode_i;
                end
                if (load_i) begin
                    lfsr_d   = ns_next;
                    lock_set = ns_recover;
                end
                if (start_i) begin
                    if (burst_len_i != '0) begin
                        cnt_d = burst_len_i;
                        st_d  = StRun;
                    end else begin
                        st_d  = StDone;
                    end
                end
            end
            StRun: begin
                if (out_ready_i) begin
                    lfsr_d   = ns_next;
                    lock_set = ns_recover;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        st_d = StDone;
                    end
                end
            end
            StDone:  st_d = StIdle;
            default: st_d = StIdle;
        endcase
        // Recovery on this edge outranks a simultaneous clear.
        lockup_d = lock_set | (lockup_q & ~lockup_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q     <= StIdle;
            cnt_q    <= '0;
            lfsr_q   <= RESET_SEED;
            taps_q   <= '0;
            xnor_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            taps_q   <= taps_d;
            xnor_q   <= xnor_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_valid_o = (st_q == StRun);
    assign busy_o      = (st_q == StRun);
    assign done_o      = (st_q == StDone);
    assign out_data_o  = lfsr_q;
    assign lockup_o    = lockup_q;

endmodule
